// File: rtl/stage_ex_pkg.sv
// Shared definitions for the MIPS execute stage: operator codes, divider states
// and the HI/LO operator classifier.
package stage_ex_pkg;

    localparam logic [7:0] OP_SLL   = 8'h00;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_SLTU  = 8'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} div_state_t;

    // Operators whose only architectural effect is on HI/LO; they never write the register file.
    function automatic logic is_hilo_op(input logic [7:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
               (op == OP_DIVU) || (op == OP_MTHI)  || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider (one quotient bit per cycle) with IDLE/BUSY/FIX FSM.
// Used by stage_ex_muldiv only when STAGE_EX_DIV_EN is defined.
module ex_divider
    import stage_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CW = $clog2(DATA_WIDTH);

    div_state_t            state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] div_abs;
    logic                  neg_q;
    logic                  neg_r;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH:0]   trial;

    assign a_neg = signed_op & dividend[DATA_WIDTH-1];
    assign b_neg = signed_op & divisor[DATA_WIDTH-1];

    // quo doubles as the shifting dividend: its MSB feeds the partial remainder each step.
    assign trial = {rem, quo[DATA_WIDTH-1]} - {1'b0, div_abs};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            div_abs <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= a_neg ? -dividend : dividend;
                        div_abs <= b_neg ? -divisor : divisor;
                        rem     <= '0;
                        count   <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!trial[DATA_WIDTH]) begin
                        rem <= trial[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
                        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign done      = (state == FIX);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/stage_ex_muldiv.sv
// MIPS execute stage with EX/MEM register, HI/LO, multiply and optional iterative divide.
// Define STAGE_EX_DIV_EN to build the multi-cycle divider; otherwise DIV/DIVU are 1-cycle no-ops.
module stage_ex_muldiv
    import stage_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   operator,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  id_register_write_enable,
    input  logic [ADDR_WIDTH-1:0] id_register_write_address,
    output logic                  out_valid,
    output logic                  register_write_enable,
    output logic [ADDR_WIDTH-1:0] register_write_address,
    output logic [DATA_WIDTH-1:0] register_write_data,
    output logic [DATA_WIDTH-1:0] hi_value,
    output logic [DATA_WIDTH-1:0] lo_value
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [7:0]              op_code;
    logic                    accept;
    logic                    is_div;
    logic                    div_start;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   div_quo;
    logic [DATA_WIDTH-1:0]   div_rem;
    logic [SHW-1:0]          shamt;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_known;
    logic                    next_we;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_u;

    assign op_code = 8'(operator);
    assign accept  = in_valid && in_ready && !flush;
    assign is_div  = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign shamt   = operand_a[SHW-1:0];

    // Signed product taken as the low 2W bits of an unsigned multiply of sign-extended operands.
    assign prod_s = {{DATA_WIDTH{operand_a[DATA_WIDTH-1]}}, operand_a} *
                    {{DATA_WIDTH{operand_b[DATA_WIDTH-1]}}, operand_b};
    assign prod_u = {{DATA_WIDTH{1'b0}}, operand_a} * {{DATA_WIDTH{1'b0}}, operand_b};

`ifdef STAGE_EX_DIV_EN
    assign div_start = accept && is_div && (operand_b != '0);

    ex_divider #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_divider (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .start     (div_start),
        .signed_op (op_code == OP_DIV),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .ready     (in_ready),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign div_start = 1'b0;
    assign div_done  = 1'b0;
    assign div_quo   = '0;
    assign div_rem   = '0;
    assign in_ready  = 1'b1;
`endif

    always_comb begin
        alu_result = '0;
        alu_known  = 1'b1;
        case (op_code)
            OP_OR:   alu_result = operand_a | operand_b;
            OP_AND:  alu_result = operand_a & operand_b;
            OP_XOR:  alu_result = operand_a ^ operand_b;
            OP_NOR:  alu_result = ~(operand_a | operand_b);
            OP_ADDU: alu_result = operand_a + operand_b;
            OP_SUBU: alu_result = operand_a - operand_b;
            OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, operand_a < operand_b};
            OP_SLL:  alu_result = operand_b << shamt;
            OP_SRL:  alu_result = operand_b >> shamt;
            OP_SRA:  alu_result = $signed(operand_b) >>> shamt;
            OP_MFHI: alu_result = hi_value;
            OP_MFLO: alu_result = lo_value;
            OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_result = '0;
            default: alu_known = 1'b0;
        endcase
    end

    assign next_we = alu_known && !is_hilo_op(op_code) && id_register_write_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid              <= 1'b0;
            register_write_enable  <= 1'b0;
            register_write_address <= '0;
            register_write_data    <= '0;
            hi_value               <= '0;
            lo_value               <= '0;
        end else if (flush) begin
            out_valid             <= 1'b0;
            register_write_enable <= 1'b0;
        end else if (div_done) begin
            out_valid             <= 1'b1;
            register_write_enable <= 1'b0;
            hi_value              <= div_rem;
            lo_value              <= div_quo;
        end else if (accept) begin
            // A division handed to the divider pulses out_valid only when it finishes.
            out_valid              <= !div_start;
            register_write_enable  <= next_we;
            register_write_address <= id_register_write_address;
            register_write_data    <= alu_result;
            case (op_code)
                OP_MTHI:  hi_value <= operand_a;
                OP_MTLO:  lo_value <= operand_a;
                OP_MULT:  {hi_value, lo_value} <= prod_s;
                OP_MULTU: {hi_value, lo_value} <= prod_u;
`ifdef STAGE_EX_DIV_EN
                OP_DIV, OP_DIVU: begin
                    if (operand_b == '0) begin
                        lo_value <= '1;
                        hi_value <= operand_a;
                    end
                end
`endif
                default: ;
            endcase
        end else begin
            out_valid             <= 1'b0;
            register_write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Directed self-checking bench for stage_ex_muldiv (divider checks follow STAGE_EX_DIV_EN).
module tb_stage_ex_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  operator = 8'h00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        id_we = 1'b0;
    logic [4:0]  id_addr = '0;
    logic        out_valid;
    logic        rwe;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] hi_value;
    logic [31:0] lo_value;

    int assert_count = 0;
    int fail_count   = 0;

    stage_ex_muldiv #(
        .DATA_WIDTH(32),
        .OP_WIDTH  (8),
        .ADDR_WIDTH(5)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .operator                  (operator),
        .operand_a                 (operand_a),
        .operand_b                 (operand_b),
        .id_register_write_enable  (id_we),
        .id_register_write_address (id_addr),
        .out_valid                 (out_valid),
        .register_write_enable     (rwe),
        .register_write_address    (raddr),
        .register_write_data       (rdata),
        .hi_value                  (hi_value),
        .lo_value                  (lo_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] addr);
        in_valid  = 1'b1;
        operator  = op;
        operand_a = a;
        operand_b = b;
        id_we     = we;
        id_addr   = addr;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b, 1'b1, 5'd9);
        tick();
        in_valid = 1'b0;
    endtask

    int cycles;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_we", rwe, 0);
        check("reset_data", rdata, 0);
        check("reset_hi", hi_value, 0);
        check("reset_lo", lo_value, 0);
        check("reset_ready", in_ready, 1);
        reset = 1'b0;
        tick();

        // Back-to-back OR then SUBU
        drive(8'h25, 32'h0000F0F0, 32'h00000F0F, 1'b1, 5'd3);
        tick();
        check("or_valid", out_valid, 1);
        check("or_data", rdata, 32'h0000FFFF);
        check("or_we", rwe, 1);
        check("or_addr", raddr, 3);
        drive(8'h23, 32'd5, 32'd7, 1'b1, 5'd4);
        tick();
        in_valid = 1'b0;
        check("subu_valid", out_valid, 1);
        check("subu_data", rdata, 32'hFFFFFFFE);
        check("subu_addr", raddr, 4);
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_we", rwe, 0);

        // Compare and shifts
        issue(8'h2A, 32'hFFFFFFFF, 32'd1);
        check("slt", rdata, 1);
        issue(8'h2B, 32'hFFFFFFFF, 32'd1);
        check("sltu", rdata, 0);
        issue(8'h03, 32'd4, 32'h80000000);
        check("sra", rdata, 32'hF8000000);
        issue(8'h02, 32'd4, 32'h80000000);
        check("srl", rdata, 32'h08000000);
        issue(8'h00, 32'd31, 32'h00000003);
        check("sll", rdata, 32'h80000000);
        issue(8'h27, 32'h0F0F0000, 32'h000000F0);
        check("nor", rdata, 32'hF0F0FF0F);
        issue(8'h21, 32'hFFFFFFFF, 32'd2);
        check("addu_wrap", rdata, 32'h00000001);
        issue(8'h3F, 32'd1, 32'd2);
        check("unknown_valid", out_valid, 1);
        check("unknown_we", rwe, 0);
        check("unknown_data", rdata, 0);

        // MULT then MFHI/MFLO back-to-back
        drive(8'h18, 32'hFFFFFFFE, 32'd3, 1'b1, 5'd9);
        tick();
        check("mult_valid", out_valid, 1);
        check("mult_we", rwe, 0);
        drive(8'h10, 32'd0, 32'd0, 1'b1, 5'd5);
        tick();
        check("mfhi", rdata, 32'hFFFFFFFF);
        check("mfhi_we", rwe, 1);
        drive(8'h12, 32'd0, 32'd0, 1'b1, 5'd6);
        tick();
        in_valid = 1'b0;
        check("mflo", rdata, 32'hFFFFFFFA);
        issue(8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_hi", hi_value, 32'hFFFFFFFE);
        check("multu_lo", lo_value, 32'h00000001);
        issue(8'h11, 32'h12345678, 32'd0);
        check("mthi", hi_value, 32'h12345678);
        issue(8'h13, 32'h9ABCDEF0, 32'd0);
        check("mtlo", lo_value, 32'h9ABCDEF0);
        check("mtlo_we", rwe, 0);

        // Flush beats a simultaneous in_valid
        flush = 1'b1;
        issue(8'h11, 32'hDEADBEEF, 32'd0);
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_we", rwe, 0);
        check("flush_hi", hi_value, 32'h12345678);

`ifdef STAGE_EX_DIV_EN
        // DIV -7/2 with an MFLO held behind it
        issue(8'h1A, 32'hFFFFFFF9, 32'd2);
        drive(8'h12, 32'd0, 32'd0, 1'b1, 5'd7);
        check("div_ready_e0", in_ready, 0);
        check("div_valid_e0", out_valid, 0);
        cycles = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (in_ready) break;
            cycles++;
        end
        check("div_stall_cycles", cycles, 33);
        check("div_done_valid", out_valid, 1);
        check("div_done_we", rwe, 0);
        check("div_lo", lo_value, 32'hFFFFFFFD);
        check("div_hi", hi_value, 32'hFFFFFFFF);
        tick();
        in_valid = 1'b0;
        check("mflo_after_div", rdata, 32'hFFFFFFFD);
        check("mflo_after_div_valid", out_valid, 1);

        // Most-negative / -1
        issue(8'h1A, 32'h80000000, 32'hFFFFFFFF);
        repeat (33) tick();
        check("div_ovf_lo", lo_value, 32'h80000000);
        check("div_ovf_hi", hi_value, 32'h00000000);

        // DIVU by zero completes at accept
        issue(8'h1B, 32'd9, 32'd0);
        check("div0_valid", out_valid, 1);
        check("div0_lo", lo_value, 32'hFFFFFFFF);
        check("div0_hi", hi_value, 32'd9);
        check("div0_ready", in_ready, 1);

        // DIVU 100/7 complete
        issue(8'h1B, 32'd100, 32'd7);
        repeat (33) tick();
        check("divu_lo", lo_value, 32'd14);
        check("divu_hi", hi_value, 32'd2);

        // DIVU 100/7 flushed at busy cycle 10
        issue(8'h13, 32'h0000AAAA, 32'd0);
        issue(8'h1B, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("dflush_ready", in_ready, 1);
        check("dflush_valid", out_valid, 0);
        repeat (40) tick();
        check("dflush_lo", lo_value, 32'h0000AAAA);
        check("dflush_hi", hi_value, 32'd2);
`else
        // Divider absent: DIV/DIVU are single-cycle with HI/LO untouched
        issue(8'h1A, 32'hFFFFFFF9, 32'd2);
        check("div_ready", in_ready, 1);
        check("div_valid", out_valid, 1);
        check("div_we", rwe, 0);
        check("div_hi", hi_value, 32'h12345678);
        check("div_lo", lo_value, 32'h9ABCDEF0);
        issue(8'h1B, 32'd9, 32'd0);
        check("div0_valid", out_valid, 1);
        check("div0_lo", lo_value, 32'h9ABCDEF0);
        check("div0_hi", hi_value, 32'h12345678);
`endif

        // Asynchronous reset in the middle of an operation
        issue(8'h1B, 32'd100, 32'd7);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_we", rwe, 0);
        check("areset_addr", raddr, 0);
        check("areset_data", rdata, 0);
        check("areset_hi", hi_value, 0);
        check("areset_lo", lo_value, 0);
        check("areset_ready", in_ready, 1);
        #1;
        reset = 1'b0;
        repeat (40) tick();
        check("areset_hi_stays", hi_value, 0);
        check("areset_lo_stays", lo_value, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
